branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the pipelined CPU: a direct-mapped table of saturating counters with tags and targets, replacing the single-bit taken/not-taken guess carried from IF to EX. IF queries it combinationally with the fetch PC and receives a predicted next PC. EX reports each resolved control-flow instruction, and the block returns the mispredict flag and redirect PC that drive the pipeline flush. Optional global-history (gshare) indexing is selected at compile time.

---
 rtl/bp_pkg.sv | 43 ++++
 rtl/bp_perf_counter.sv | 30 +++
 rtl/branch_predictor.sv | 141 ++++++++++++++
 tb/tb_branch_predictor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Summary  : Shared types, counter constants and saturating-step helper for
//            the branch predictor table.
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

   // Default table geometry; bp_entry_t is sized from it, so branch_predictor
   // must be built with matching DATA_W/ENTRIES/CNT_W.
   localparam int BP_DATA_W  = 32;
   localparam int BP_ENTRIES = 64;
   localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
   localparam int BP_TAG_W   = BP_DATA_W - BP_IDX_W - 2;
   localparam int BP_CNT_W   = 2;

   localparam logic [BP_CNT_W-1:0] CNT_RESET = BP_CNT_W'((1 << (BP_CNT_W - 1)) - 1);
   localparam logic [BP_CNT_W-1:0] CNT_ALLOC = BP_CNT_W'(1 << (BP_CNT_W - 1));

   typedef struct packed {
      logic                 valid;
      logic [BP_TAG_W-1:0]  tag;
      logic [BP_DATA_W-1:0] target;
      logic [BP_CNT_W-1:0]  cnt;
   } bp_entry_t;

   localparam bp_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_RESET};

   function automatic logic [BP_CNT_W-1:0] sat_step(input logic [BP_CNT_W-1:0] cnt,
                                                    input logic                up);
      logic [BP_CNT_W-1:0] res;
      res = cnt;
      if (up) begin
         if (!(&cnt)) res = cnt + 1'b1;
      end else begin
         if (|cnt) res = cnt - 1'b1;
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : bp_perf_counter
// Summary  : 32-bit performance counter that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module bp_perf_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= 32'd0;
      else      count_q <= count_d;
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Summary  : Direct-mapped tag/target/saturating-counter predictor; define
//            BP_GSHARE_EN to XOR a global history register into the index.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor
   import bp_pkg::*;
#(
   parameter int DATA_W  = BP_DATA_W,
   parameter int ENTRIES = BP_ENTRIES,
   parameter int CNT_W   = BP_CNT_W,
   parameter int HIST_W  = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [DATA_W-1:0] pc_in,
   output logic              predict_taken,
   output logic [DATA_W-1:0] predict_pc,
   output logic [HIST_W-1:0] lookup_hist,
   input  logic              upd_valid,
   input  logic              upd_is_branch,
   input  logic [DATA_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [DATA_W-1:0] upd_target,
   input  logic [DATA_W-1:0] upd_predicted_pc,
   input  logic [HIST_W-1:0] upd_hist,
   output logic              mispredict,
   output logic [DATA_W-1:0] redirect_pc,
   output logic [31:0]       branch_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);

   bp_entry_t         table_q [ENTRIES];
   bp_entry_t         entry_d;
   logic              tbl_we;

   logic [IDX_W-1:0]  w_lk_idx;
   logic [IDX_W-1:0]  w_up_idx;
   bp_entry_t         w_lk_ent;
   bp_entry_t         w_up_ent;
   logic              w_lk_hit;
   logic              w_up_hit;
   logic [DATA_W-1:0] w_actual_pc;
   logic              w_commit;

   assign w_commit = upd_valid && !stall;

`ifdef BP_GSHARE_EN
   logic [HIST_W-1:0] ghr_q;
   logic [HIST_W-1:0] ghr_d;

   assign w_lk_idx    = pc_in[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign w_up_idx    = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_hist);
   assign lookup_hist = ghr_q;

   // Newest outcome enters at bit 0; the oldest falls off the top.
   always_comb begin
      ghr_d = ghr_q;
      if (w_commit && upd_is_branch) ghr_d = HIST_W'({ghr_q, upd_taken});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ghr_q <= '0;
      else      ghr_q <= ghr_d;
   end
`else
   logic w_unused_hist;

   assign w_lk_idx      = pc_in[IDX_W+1:2];
   assign w_up_idx      = upd_pc[IDX_W+1:2];
   assign lookup_hist   = '0;
   assign w_unused_hist = ^upd_hist;
`endif

   // Lookup path
   assign w_lk_ent      = table_q[w_lk_idx];
   assign w_lk_hit      = w_lk_ent.valid && (w_lk_ent.tag == pc_in[DATA_W-1:IDX_W+2]);
   assign predict_taken = w_lk_hit && w_lk_ent.cnt[CNT_W-1];
   assign predict_pc    = predict_taken ? w_lk_ent.target : pc_in + DATA_W'(4);

   // Resolution path
   assign w_actual_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + DATA_W'(4);
   assign mispredict  = upd_valid && (upd_predicted_pc != w_actual_pc);
   assign redirect_pc = w_actual_pc;

   assign w_up_ent = table_q[w_up_idx];
   assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == upd_pc[DATA_W-1:IDX_W+2]);

   always_comb begin
      entry_d = w_up_ent;
      tbl_we  = 1'b0;
      if (w_commit) begin
         if (upd_is_branch) begin
            if (w_up_hit) begin
               tbl_we      = 1'b1;
               entry_d.cnt = sat_step(w_up_ent.cnt, upd_taken);
               if (upd_taken) entry_d.target = upd_target;
            end else if (upd_taken) begin
               tbl_we         = 1'b1;
               entry_d.valid  = 1'b1;
               entry_d.tag    = upd_pc[DATA_W-1:IDX_W+2];
               entry_d.target = upd_target;
               entry_d.cnt    = CNT_ALLOC;
            end
         end else if (mispredict) begin
            // A non-branch predicted taken means the entry aliases stale code.
            tbl_we        = 1'b1;
            entry_d.valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) table_q[i] <= ENTRY_RESET;
      end else if (tbl_we) begin
         table_q[w_up_idx] <= entry_d;
      end
   end

   bp_perf_counter u_branch_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (w_commit && upd_is_branch),
      .count_o (branch_cnt)
   );

   bp_perf_counter u_miss_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (w_commit && mispredict),
      .count_o (miss_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Summary  : Scoreboard bench for branch_predictor against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   localparam int DW = 32;
   localparam int EN = 64;
   localparam int IW = 6;
   localparam int CW = 2;
   localparam int HW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic [DW-1:0] pc_in;
   logic          predict_taken;
   logic [DW-1:0] predict_pc;
   logic [HW-1:0] lookup_hist;
   logic          upd_valid;
   logic          upd_is_branch;
   logic [DW-1:0] upd_pc;
   logic          upd_taken;
   logic [DW-1:0] upd_target;
   logic [DW-1:0] upd_predicted_pc;
   logic [HW-1:0] upd_hist;
   logic          mispredict;
   logic [DW-1:0] redirect_pc;
   logic [31:0]   branch_cnt;
   logic [31:0]   miss_cnt;

   branch_predictor #(.DATA_W(DW), .ENTRIES(EN), .CNT_W(CW), .HIST_W(HW)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .pc_in            (pc_in),
      .predict_taken    (predict_taken),
      .predict_pc       (predict_pc),
      .lookup_hist      (lookup_hist),
      .upd_valid        (upd_valid),
      .upd_is_branch    (upd_is_branch),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_predicted_pc (upd_predicted_pc),
      .upd_hist         (upd_hist),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .branch_cnt       (branch_cnt),
      .miss_cnt         (miss_cnt)
   );

   always #5 clk = ~clk;

   typedef enum {K_PT, K_PPC, K_HIST, K_MISP, K_RPC, K_BCNT, K_MCNT} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       n_checks = 0;
   int       n_fail   = 0;
   string    g_ctx    = "init";

   // Reference model state
   bit            m_v   [EN];
   logic [DW-IW-3:0] m_tag [EN];
   logic [DW-1:0] m_tgt [EN];
   logic [CW-1:0] m_cnt [EN];
   logic [HW-1:0] m_ghr;
   logic [31:0]   m_br;
   logic [31:0]   m_miss;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: observed 0x%0h required 0x%0h", g_ctx, tag, obs, exp);
      end
   endtask

   function automatic void sb_push(input kind_e k, input logic [31:0] v);
      sb_item_t it;
      it.kind = k;
      it.exp  = v;
      sb_q.push_back(it);
   endfunction

   task automatic sb_drain();
      sb_item_t it;
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         case (it.kind)
            K_PT:    chk("predict_taken", {31'd0, predict_taken}, it.exp);
            K_PPC:   chk("predict_pc", predict_pc, it.exp);
            K_HIST:  chk("lookup_hist", {26'd0, lookup_hist}, it.exp);
            K_MISP:  chk("mispredict", {31'd0, mispredict}, it.exp);
            K_RPC:   chk("redirect_pc", redirect_pc, it.exp);
            K_BCNT:  chk("branch_cnt", branch_cnt, it.exp);
            default: chk("miss_cnt", miss_cnt, it.exp);
         endcase
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < EN; i++) begin
         m_v[i]   = 1'b0;
         m_tag[i] = '0;
         m_tgt[i] = '0;
         m_cnt[i] = CW'(1);
      end
      m_ghr  = '0;
      m_br   = '0;
      m_miss = '0;
   endfunction

   function automatic logic [IW-1:0] m_idx(input logic [DW-1:0] pc, input logic [HW-1:0] h);
`ifdef BP_GSHARE_EN
      return pc[IW+1:2] ^ IW'(h);
`else
      return pc[IW+1:2] ^ (IW'(h) & IW'(0));
`endif
   endfunction

   function automatic logic [HW-1:0] m_hist();
`ifdef BP_GSHARE_EN
      return m_ghr;
`else
      return '0;
`endif
   endfunction

   function automatic void m_pred(input logic [DW-1:0] pc, output logic t, output logic [DW-1:0] npc);
      logic [IW-1:0] i;
      i   = m_idx(pc, m_hist());
      t   = m_v[i] && (m_tag[i] == pc[DW-1:IW+2]) && m_cnt[i][CW-1];
      npc = t ? m_tgt[i] : pc + 32'd4;
   endfunction

   function automatic void m_update(input logic ub, input logic [DW-1:0] upc, input logic ut,
                                    input logic [DW-1:0] utgt, input logic [HW-1:0] uh,
                                    input logic misp);
      logic [IW-1:0] i;
      logic          hit;
      i   = m_idx(upc, uh);
      hit = m_v[i] && (m_tag[i] == upc[DW-1:IW+2]);
      if (ub) begin
         if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
         if (hit) begin
            if (ut) begin
               if (m_cnt[i] != 2'b11) m_cnt[i] = m_cnt[i] + 1'b1;
               m_tgt[i] = utgt;
            end else if (m_cnt[i] != 2'b00) begin
               m_cnt[i] = m_cnt[i] - 1'b1;
            end
         end else if (ut) begin
            m_v[i]   = 1'b1;
            m_tag[i] = upc[DW-1:IW+2];
            m_tgt[i] = utgt;
            m_cnt[i] = 2'b10;
         end
`ifdef BP_GSHARE_EN
         m_ghr = {m_ghr[HW-2:0], ut};
`endif
      end else if (misp) begin
         m_v[i] = 1'b0;
      end
      if (misp && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
   endfunction

   // One cycle: drive, queue the model's expectations, check before the edge,
   // then let the edge commit and advance the model.
   task automatic do_cycle(input string ctx, input logic [DW-1:0] pc, input logic uv,
                           input logic ub, input logic [DW-1:0] upc, input logic ut,
                           input logic [DW-1:0] utgt, input logic [DW-1:0] uppc,
                           input logic [HW-1:0] uh, input logic st);
      logic          et;
      logic [DW-1:0] epc;
      logic [DW-1:0] anpc;
      logic          emisp;
      g_ctx            = ctx;
      pc_in            = pc;
      upd_valid        = uv;
      upd_is_branch    = ub;
      upd_pc           = upc;
      upd_taken        = ut;
      upd_target       = utgt;
      upd_predicted_pc = uppc;
      upd_hist         = uh;
      stall            = st;
      m_pred(pc, et, epc);
      anpc  = (ub && ut) ? utgt : upc + 32'd4;
      emisp = uv && (uppc != anpc);
      sb_push(K_PT, {31'd0, et});
      sb_push(K_PPC, epc);
      sb_push(K_HIST, {26'd0, m_hist()});
      sb_push(K_MISP, {31'd0, emisp});
      sb_push(K_RPC, anpc);
      sb_push(K_BCNT, m_br);
      sb_push(K_MCNT, m_miss);
      #2;
      sb_drain();
      @(posedge clk);
      #1;
      if (uv && !st) m_update(ub, upc, ut, utgt, uh, emisp);
   endtask

   task automatic idle(input string ctx, input logic [DW-1:0] pc);
      do_cycle(ctx, pc, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic branch(input string ctx, input logic [DW-1:0] upc, input logic ut,
                         input logic [DW-1:0] utgt, input logic [DW-1:0] uppc);
      do_cycle(ctx, upc, 1'b1, 1'b1, upc, ut, utgt, uppc, m_hist(), 1'b0);
   endtask

   initial begin
      logic [DW-1:0] rpc;
      logic [DW-1:0] rtgt;
      logic [DW-1:0] rppc;
      logic          rt;
      logic [DW-1:0] dummy_pc;

      rst = 1'b0;
      m_reset();
      idle("in_reset", 32'h100);
      rst = 1'b1;

      idle("reset_lookup", 32'h100);
      chk("reset_ppc_const", predict_pc, 32'h104);

      branch("br_taken_alloc", 32'h100, 1'b1, 32'h200, 32'h104);
      idle("lookup_taken", 32'h100);

      branch("nt_first", 32'h100, 1'b0, 32'h200, 32'h200);
      idle("lookup_weak_nt", 32'h100);
      branch("nt_second", 32'h100, 1'b0, 32'h200, 32'h104);
      branch("nt_sat", 32'h100, 1'b0, 32'h200, 32'h104);
      branch("t_from_zero", 32'h100, 1'b1, 32'h200, 32'h104);
      idle("lookup_after_sat", 32'h100);

      for (int k = 0; k < 3; k++)
         do_cycle("stalled", 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h300, 32'h144, m_hist(), 1'b1);
      do_cycle("stall_release", 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h300, 32'h144, m_hist(), 1'b0);
      idle("lookup_after_stall", 32'h140);

      branch("train_up1", 32'h100, 1'b1, 32'h200, 32'h104);
      branch("train_up2", 32'h100, 1'b1, 32'h200, 32'h200);
      idle("lookup_trained", 32'h100);
      do_cycle("nonbranch_stale", 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h200, m_hist(), 1'b0);
      idle("lookup_invalidated", 32'h100);

      idle("wrap", 32'hFFFF_FFFC);
      chk("wrap_const", predict_pc, 32'h0000_0000);

`ifdef BP_GSHARE_EN
      do_cycle("gs_h0", 32'h1C0, 1'b1, 1'b1, 32'h1C0, 1'b1, 32'h500, 32'h1C4, 6'd0, 1'b0);
      do_cycle("gs_h1", 32'h1C0, 1'b1, 1'b1, 32'h1C0, 1'b1, 32'h600, 32'h1C4, 6'd1, 1'b0);
      idle("gs_lookup", 32'h1C0);
`endif

      // Reset asserted mid-stall clears state without waiting for an edge.
      g_ctx            = "rst_mid_stall";
      pc_in            = 32'h140;
      stall            = 1'b1;
      upd_valid        = 1'b1;
      upd_is_branch    = 1'b1;
      upd_pc           = 32'h140;
      upd_taken        = 1'b1;
      upd_target       = 32'h300;
      upd_predicted_pc = 32'h144;
      #2;
      rst = 1'b0;
      #1;
      m_reset();
      chk("branch_cnt", branch_cnt, 32'd0);
      chk("miss_cnt", miss_cnt, 32'd0);
      chk("predict_taken", {31'd0, predict_taken}, 32'd0);
      chk("predict_pc", predict_pc, 32'h144);
      chk("lookup_hist", {26'd0, lookup_hist}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle("post_reset", 32'h140);

      for (int n = 0; n < 400; n++) begin
         rpc  = (32'($urandom_range(1, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
         rtgt = 32'($urandom_range(1, 4)) << 10;
         rt   = ($urandom_range(0, 2) != 0);
         m_pred(rpc, rt, rppc);
         rt   = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) rppc = rppc + 32'd8;
         dummy_pc = (32'($urandom_range(1, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
         do_cycle("random", dummy_pc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  rpc, rt, rtgt, rppc, m_hist(), ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
